// File: rtl/calc_pkg.sv
// Shared types for the iterative calculator: opcode and control-state encodings.
// Ports: none (package).
// Imported by iterative_calculator and iterative_calculator_dpath.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_MULQ = 2'b11
   } calc_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } calc_state_t;

endpackage

// File: rtl/iterative_calculator_dpath.sv
// Datapath: operand/accumulator/counter registers, add/sub/MULQ logic, shift-add step, result register.
// Ports: load_i captures operands (and the quick result), calc_i runs one multiply step,
//        last_o flags the final multiply step, result_o is the held result.
module iterative_calculator_dpath
   import calc_pkg::*;
#(
   parameter int p_nbits = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               load_i,
   input  logic               calc_i,
   input  calc_op_t           op_i,
   input  logic [p_nbits-1:0] in0_i,
   input  logic [p_nbits-1:0] in1_i,
   output logic               last_o,
   output logic [p_nbits-1:0] result_o
);

   localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;

   logic [p_nbits-1:0] a_q, a_d;
   logic [p_nbits-1:0] b_q, b_d;
   logic [p_nbits-1:0] acc_q, acc_d;
   logic [p_nbits-1:0] result_q, result_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [p_nbits-1:0] sum_ab;
   logic [p_nbits-1:0] diff_ab;
   logic [p_nbits-1:0] mulq_ab;
   logic [p_nbits-1:0] quick_res;
   logic [p_nbits-1:0] acc_step;

   // Single-cycle ops are resolved straight from the inputs on the accept edge.
   assign sum_ab  = in0_i + in1_i;
   assign diff_ab = in0_i + ~in1_i + {{(p_nbits-1){1'b0}}, 1'b1};
   // in0 * in1[1:0] as two gated partial products.
   assign mulq_ab = (in1_i[0] ? in0_i : '0) + (in1_i[1] ? (in0_i << 1) : '0);

   // Ternaries rather than a case so an X opcode stays X on the result.
   assign quick_res = (op_i == OP_ADD) ? sum_ab  :
                      (op_i == OP_SUB) ? diff_ab : mulq_ab;

   assign acc_step = acc_q + (b_q[0] ? a_q : '0);
   assign last_o   = (cnt_q == CW'(p_nbits - 1));
   assign result_o = result_q;

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (load_i) begin
         a_d   = in0_i;
         b_d   = in1_i;
         acc_d = '0;
         cnt_d = '0;
         if (op_i != OP_MUL) begin
            result_d = quick_res;
         end
      end else if (calc_i) begin
         acc_d = acc_step;
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         cnt_d = cnt_q + CW'(1);
         // Final step: the accumulated sum becomes the result as we enter DONE.
         if (last_o) begin
            result_d = acc_step;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

endmodule

// File: rtl/iterative_calculator.sv
// Multi-cycle calculator: ADD/SUB/MULQ in 1 cycle, full shift-add MUL in p_nbits+1 cycles.
// Ports: val/rdy input stream (in0, in1, op), val/rdy output stream (result).
// Only one op in flight; input is refused until the result has been taken.
module iterative_calculator
   import calc_pkg::*;
#(
   parameter int p_nbits = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               istream_val,
   output logic               istream_rdy,
   input  logic [p_nbits-1:0] in0,
   input  logic [p_nbits-1:0] in1,
   input  logic [1:0]         op,
   output logic               ostream_val,
   input  logic               ostream_rdy,
   output logic [p_nbits-1:0] result
);

   calc_state_t state_q, state_d;
   logic        load_en;
   logic        calc_en;
   logic        calc_last;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Ternaries keep an X on istream_val/op visible in state_d.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = istream_val ? ((op == OP_MUL) ? CALC : DONE) : IDLE;
         CALC:    state_d = calc_last ? DONE : CALC;
         DONE:    state_d = ostream_rdy ? IDLE : DONE;
         default: state_d = state_q;
      endcase
   end

   // Output / control decode.
   always_comb begin
      istream_rdy = (state_q == IDLE);
      ostream_val = (state_q == DONE);
      calc_en     = (state_q == CALC);
      load_en     = istream_val & istream_rdy;
   end

   iterative_calculator_dpath #(
      .p_nbits (p_nbits)
   ) u_dpath (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (load_en),
      .calc_i   (calc_en),
      .op_i     (calc_op_t'(op)),
      .in0_i    (in0),
      .in1_i    (in1),
      .last_o   (calc_last),
      .result_o (result)
   );

endmodule

// File: tb/tb_iterative_calculator.sv
// Self-checking bench for iterative_calculator (p_nbits=16): directed cases, reset mid-MUL,
// backpressure, and 50 random ops against a plain-arithmetic reference.
module tb_iterative_calculator;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         istream_val;
   logic         istream_rdy;
   logic [N-1:0] in0;
   logic [N-1:0] in1;
   logic [1:0]   op;
   logic         ostream_val;
   logic         ostream_rdy;
   logic [N-1:0] result;

   int total = 0;
   int bad   = 0;

   iterative_calculator #(.p_nbits(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .in0         (in0),
      .in1         (in1),
      .op          (op),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .result      (result)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain modular arithmetic straight from the opcode definitions.
   function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] x,
                                          input logic [N-1:0] y);
      longint unsigned r;
      case (o)
         2'd0:    r = longint'(x) + longint'(y);
         2'd1:    r = longint'(x) - longint'(y);
         2'd2:    r = longint'(x) * longint'(y);
         default: r = longint'(x) * longint'(y % 4);
      endcase
      return N'(r);
   endfunction

   // Issue one op, check latency/result/rdy, optionally hold backpressure, then consume.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [N-1:0] x,
                         input logic [N-1:0] y, input int hold);
      logic [N-1:0] exp;
      int           lat;
      int           n;
      exp = model(o, x, y);
      lat = (o == 2'd2) ? N + 1 : 1;
      check({tag, "_rdy_before"}, {31'd0, istream_rdy}, 32'd1);
      in0 = x; in1 = y; op = o; istream_val = 1'b1;
      tick();
      istream_val = 1'b0;
      in0 = N'($urandom); in1 = N'($urandom); op = 2'($urandom);
      n = 1;
      while (!ostream_val && n < 40) begin
         check({tag, "_rdy_busy"}, {31'd0, istream_rdy}, 32'd0);
         tick();
         n++;
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_result"}, {16'd0, result}, {16'd0, exp});
      check({tag, "_rdy_done"}, {31'd0, istream_rdy}, 32'd0);
      for (int k = 0; k < hold; k++) begin
         tick();
         check({tag, "_hold_val"}, {31'd0, ostream_val}, 32'd1);
         check({tag, "_hold_res"}, {16'd0, result}, {16'd0, exp});
         check({tag, "_hold_rdy"}, {31'd0, istream_rdy}, 32'd0);
      end
      ostream_rdy = 1'b1;
      tick();
      ostream_rdy = 1'b0;
      check({tag, "_val_after"}, {31'd0, ostream_val}, 32'd0);
      check({tag, "_rdy_after"}, {31'd0, istream_rdy}, 32'd1);
   endtask

   initial begin
      logic [1:0]   ro;
      logic [N-1:0] rx;
      logic [N-1:0] ry;
      rst = 1'b1; istream_val = 1'b0; ostream_rdy = 1'b0;
      in0 = '0; in1 = '0; op = 2'd0;
      tick();
      tick();
      rst = 1'b0;
      check("reset_rdy", {31'd0, istream_rdy}, 32'd1);
      check("reset_val", {31'd0, ostream_val}, 32'd0);
      check("reset_res", {16'd0, result}, 32'd0);

      run_op("add_wrap", 2'd0, 16'h8000, 16'h8000, 0);
      check("add_wrap_const", {16'd0, model(2'd0, 16'h8000, 16'h8000)}, 32'h0000);
      run_op("add_ff",   2'd0, 16'h00FF, 16'h00FF, 0);
      run_op("sub_neg",  2'd1, 16'h0000, 16'h0001, 0);
      run_op("sub_1",    2'd1, 16'h1235, 16'h0001, 0);
      run_op("mul_3x5",  2'd2, 16'h0003, 16'h0005, 0);
      run_op("mul_ffff", 2'd2, 16'hFFFF, 16'h0003, 0);
      run_op("mul_ff",   2'd2, 16'h00FF, 16'h0101, 0);
      run_op("mulq_7",   2'd3, 16'hFFFF, 16'h0007, 0);
      run_op("mulq_ovf", 2'd3, 16'h8000, 16'h0002, 0);
      run_op("bp_5",     2'd0, 16'h1111, 16'h2222, 5);

      // Put a nonzero result in place, then reset in cycle 6 of a MUL.
      run_op("pre_rst",  2'd2, 16'h0003, 16'h0005, 0);
      in0 = 16'h1234; in1 = 16'h0003; op = 2'd2; istream_val = 1'b1;
      tick();
      istream_val = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_rdy", {31'd0, istream_rdy}, 32'd1);
      check("midrst_val", {31'd0, ostream_val}, 32'd0);
      check("midrst_res", {16'd0, result}, 32'd0);
      run_op("post_rst", 2'd0, 16'h0002, 16'h0002, 0);

      for (int i = 0; i < 50; i++) begin
         ro = 2'($urandom);
         rx = N'($urandom);
         ry = N'($urandom);
         if (i % 10 == 0) rx = 16'hFFFF;
         run_op("rand", ro, rx, ry, int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
